// File: rtl/stack_queue_buf_pkg.sv
// stack_queue_pkg: mode encoding and count/pointer width helpers shared by stack_queue_buf
package stack_queue_pkg;
    typedef enum logic {MODE_FIFO = 1'b0, MODE_LIFO = 1'b1} mode_e;
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/stack_queue_buf_if.sv
// stack_queue_buf_if: producer/consumer bus of stack_queue_buf
// peek_data exists only when STACK_QUEUE_BUF_PEEK_EN is defined
interface stack_queue_buf_if
    import stack_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    logic                    mode;
    logic                    push;
    logic                    pop;
    logic                    clr_err;
    logic [WIDTH-1:0]        data_in;
    logic [WIDTH-1:0]        data_out;
    logic                    out_valid;
    logic [cnt_w(DEPTH)-1:0] count;
    logic                    full;
    logic                    empty;
    logic                    almost_full;
    logic                    overflow;
    logic                    underflow;
`ifdef STACK_QUEUE_BUF_PEEK_EN
    logic [WIDTH-1:0]        peek_data;
    modport master (output mode, push, pop, clr_err, data_in,
                    input data_out, out_valid, count, full, empty, almost_full, overflow, underflow, peek_data);
    modport slave  (input mode, push, pop, clr_err, data_in,
                    output data_out, out_valid, count, full, empty, almost_full, overflow, underflow, peek_data);
`else
    modport master (output mode, push, pop, clr_err, data_in,
                    input data_out, out_valid, count, full, empty, almost_full, overflow, underflow);
    modport slave  (input mode, push, pop, clr_err, data_in,
                    output data_out, out_valid, count, full, empty, almost_full, overflow, underflow);
`endif
endinterface

// File: rtl/stack_queue_buf_mem.sv
// sqb_mem: DEPTH x WIDTH register file, one synchronous write port, one asynchronous read port
module sqb_mem
    import stack_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [ptr_w(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [ptr_w(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]          rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/stack_queue_buf.sv
// stack_queue_buf: run-time selectable LIFO/FIFO buffer with occupancy, almost-full and sticky error flags
// Define STACK_QUEUE_BUF_PEEK_EN to expose the combinational peek_data output
module stack_queue_buf
    import stack_queue_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic              clk,
    input  logic              reset_n,
    stack_queue_buf_if.slave  bus
);
    localparam int CW = cnt_w(DEPTH);
    localparam int AW = ptr_w(DEPTH);
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             is_empty, lifo, pop_ok, push_ok;
    logic [AW-1:0]    top_m1, waddr, raddr;
    logic [WIDTH-1:0] rdata;
    // The read port always points at the next entry to pop, so it doubles as the peek source
    always_comb begin
        is_empty    = count_q == '0;
        mode_d      = is_empty ? mode_e'(bus.mode) : mode_q;
        lifo        = mode_d == MODE_LIFO;
        pop_ok      = bus.pop & !is_empty;
        push_ok     = bus.push & ((count_q != CW'(DEPTH)) | pop_ok);
        top_m1      = AW'(count_q - 1'b1);
        raddr       = lifo ? top_m1 : rd_ptr_q;
        waddr       = lifo ? (pop_ok ? top_m1 : AW'(count_q)) : wr_ptr_q;
        count_d     = count_q + CW'(push_ok) - CW'(pop_ok);
        rd_ptr_d    = (!lifo && pop_ok) ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d    = (!lifo && push_ok) ? wr_ptr_q + 1'b1 : wr_ptr_q;
        data_out_d  = pop_ok ? rdata : data_out_q;
        out_valid_d = pop_ok;
        overflow_d  = (bus.push & !push_ok) | (overflow_q & !bus.clr_err);
        underflow_d = (bus.pop & !pop_ok) | (underflow_q & !bus.clr_err);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            mode_q      <= MODE_FIFO;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            mode_q      <= mode_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
    sqb_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (push_ok),
        .waddr_i (waddr),
        .wdata_i (bus.data_in),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );
    assign bus.data_out    = data_out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.count       = count_q;
    assign bus.full        = count_q == CW'(DEPTH);
    assign bus.empty       = is_empty;
    assign bus.almost_full = count_q >= CW'(AFULL_LVL);
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
`ifdef STACK_QUEUE_BUF_PEEK_EN
    assign bus.peek_data   = rdata;
`endif
endmodule

// File: tb/tb_stack_queue_buf.sv
// tb_stack_queue_buf: directed plan plus random traffic against a queue-based reference model
module tb_stack_queue_buf;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AF = D - 1;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    stack_queue_buf_if #(.WIDTH(W), .DEPTH(D)) bus ();
    stack_queue_buf #(.WIDTH(W), .DEPTH(D), .AFULL_LVL(AF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] q[$];
    logic         m_lifo, m_valid, m_ovf, m_udf;
    logic [W-1:0] m_dout;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask
    task automatic chk_all();
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("full", 32'(bus.full), 32'(q.size() == D));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= AF));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("data_out", 32'(bus.data_out), 32'(m_dout));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_udf));
`ifdef STACK_QUEUE_BUF_PEEK_EN
        if (q.size() > 0) chk("peek", 32'(bus.peek_data), 32'(m_lifo ? q[$] : q[0]));
`endif
    endtask
    task automatic model_reset();
        q.delete();
        m_lifo  = 1'b0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_dout  = '0;
    endtask
    task automatic step(input logic md, input logic ps, input logic pp, input logic [W-1:0] din, input logic clr);
        int n;
        logic pop_ok, push_ok;
        n = q.size();
        bus.mode    = md;
        bus.push    = ps;
        bus.pop     = pp;
        bus.data_in = din;
        bus.clr_err = clr;
        if (n == 0) m_lifo = md;
        pop_ok  = pp && n > 0;
        push_ok = ps && (n < D || pop_ok);
        m_valid = pop_ok;
        if (pop_ok) begin
            m_dout = m_lifo ? q[$] : q[0];
            if (m_lifo) void'(q.pop_back());
            else void'(q.pop_front());
        end
        if (push_ok) q.push_back(din);
        m_ovf = (ps && !push_ok) || (m_ovf && !clr);
        m_udf = (pp && !pop_ok) || (m_udf && !clr);
        @(posedge clk);
        #1;
        chk_all();
    endtask
    task automatic push_n(input logic md, input logic [W-1:0] base, input int k);
        for (int i = 0; i < k; i++) step(md, 1'b1, 1'b0, base + W'(i), 1'b0);
    endtask
    task automatic pop_n(input logic md, input int k);
        for (int i = 0; i < k; i++) step(md, 1'b0, 1'b1, '0, 1'b0);
    endtask
    initial begin
        bus.mode = 0; bus.push = 0; bus.pop = 0; bus.data_in = '0; bus.clr_err = 0;
        model_reset();
        #12;
        chk_all();
        reset_n = 1'b1;
        step(0, 1, 0, 8'h11, 0); step(0, 1, 0, 8'h22, 0); step(0, 1, 0, 8'h33, 0);
        pop_n(0, 3);
        push_n(1, 8'hA0, 8);
        pop_n(1, 9);
        step(0, 0, 0, '0, 1);
        push_n(1, 8'hA0, 8);
        step(1, 1, 1, 8'h5C, 0);
        pop_n(1, 8);
        push_n(0, 8'hA0, 8);
        step(0, 1, 1, 8'h5C, 0);
        pop_n(0, 8);
        push_n(0, 8'hB0, 8);
        step(0, 1, 0, 8'hEE, 0);
        step(0, 0, 0, '0, 1);
        step(0, 1, 0, 8'hEF, 0);
        step(0, 1, 0, 8'hEF, 1);
        pop_n(0, 8);
        step(0, 0, 0, '0, 1);
        push_n(0, 8'hC0, 3);
        pop_n(1, 3);
        step(1, 1, 0, 8'h01, 0); step(1, 1, 0, 8'h02, 0);
        pop_n(1, 2);
        step(0, 1, 1, 8'h77, 0);
        pop_n(0, 1);
        push_n(1, 8'hD0, 4);
        step(1, 1, 0, 8'hDD, 0);
        step(1, 0, 1, '0, 0);
        #2 reset_n = 1'b0;
        model_reset();
        #1 chk_all();
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 W'($urandom), $urandom_range(0, 99) < 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stack_queue_buf.md
Name: stack_queue_buf

Overview:
Parametrised successor to the 8x8 LIFO. It is a single storage array that runs as either a LIFO (stack) or a FIFO (queue), with the mode selected at run time while the buffer is empty. Width and depth are generic. Push and pop can happen in the same cycle, and the block reports a registered output-valid strobe, an occupancy count, almost-full, and sticky overflow/underflow errors. It sits between producer and consumer datapaths wherever the design needs a stack or a queue.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 8, number of entries; power of 2, >=2
AFULL_LVL, DEPTH-1, almost_full asserts when count >= AFULL_LVL (1..DEPTH)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
mode  in  1  0=FIFO, 1=LIFO; sampled only while empty
push  in  1  write request
pop  in  1  read request
data_in  in  WIDTH  push data
data_out  out  WIDTH  popped data, registered
out_valid  out  1  one-cycle strobe: data_out updated this cycle
count  out  $clog2(DEPTH)+1  current occupancy
full  out  1  count==DEPTH
empty  out  1  count==0
almost_full  out  1  count>=AFULL_LVL
overflow  out  1  sticky: push rejected
underflow  out  1  sticky: pop rejected
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (reset_n low, asynchronous):
  - count=0, all pointers=0, data_out=0, out_valid=0, overflow=0, underflow=0, mode_q=FIFO.
  - Memory contents are not reset.
- full, empty, almost_full are combinational decodes of registered count. They never glitch on push/pop inputs.
- Mode:
  - mode_q <= mode on every cycle where the pre-edge count==0.
  - The operation in that same cycle executes under the new mode.
  - When count>0, mode is ignored.
- Validity is judged against pre-edge state:
  - pop_ok = pop & count>0.
  - push_ok = push & (count<DEPTH | pop_ok).
- Pop latency: data_out and out_valid update on the edge that accepts the pop, i.e. one cycle latency. out_valid=0 otherwise; data_out holds its last value.
- FIFO mode:
  - Pop reads mem[rd_ptr] and increments rd_ptr.
  - Push writes mem[wr_ptr] and increments wr_ptr.
  - Both pointers are log2(DEPTH) bits and wrap naturally.
  - Push+pop together: both execute and count is unchanged. This holds when full.
- LIFO mode, top = count:
  - Push alone writes mem[top] and count+1.
  - Pop alone returns mem[top-1] and count-1.
  - Push+pop with count>0 (replace): data_out <= old mem[top-1], then mem[top-1] <= data_in; count unchanged. This holds when full.
- Empty with push+pop (either mode): the pop is rejected (underflow sets) and the push is accepted (count becomes 1). There is no bypass.
- Error flags:
  - Rejected push (push & !push_ok) sets overflow.
  - Rejected pop sets underflow.
  - Rejected operations change no state.
  - clr_err clears both flags. A simultaneous new error has priority, so the flag stays 1.
- count stays in 0..DEPTH. count width lets DEPTH itself be represented.

Optional Feature:
STACK_QUEUE_BUF_PEEK_EN
- Defined: adds output peek_data[WIDTH-1:0], combinational.
  - FIFO mode: shows mem[rd_ptr].
  - LIFO mode: shows mem[count-1].
  - Value is don't-care when empty.
  - Peeking never changes state.
- Undefined: the port is absent and no read-mux logic is added.

Decomposition:
- Package stack_queue_pkg holds:
  - MODE_FIFO=1'b0 and MODE_LIFO=1'b1 constants/typedef.
  - A clog2-based width helper for count and pointers.
- Natural sub-module: sqb_mem. It is a DEPTH x WIDTH register file with one synchronous write port and one asynchronous read port. The top level owns pointers, count, mode and flags; sqb_mem stores only.

Test Plan:
1. Reset, mode=0, push 0x11,0x22,0x33, then pop x3 -> data_out 0x11,0x22,0x33, each with out_valid=1 on the accepting edge; empty=1 after.
2. Empty, mode=1, push 0xA0..0xA7 (8 pushes) -> full=1, almost_full from count 7. Pop x8 -> 0xA7 down to 0xA0; a 9th pop sets underflow, count stays 0.
3. LIFO full, push 0x5C with pop -> data_out=0xA7, count=8, next pop=0x5C; no overflow. Repeat in FIFO full -> oldest entry out, 0x5C queued last.
4. FIFO full, push alone -> overflow=1, contents unchanged. Assert clr_err -> overflow=0. clr_err with a rejected push in the same cycle -> overflow stays 1.
5. FIFO with 3 entries, drive mode=1 -> still pops in FIFO order. Once empty, mode=1 with push 0x01,0x02 -> pops 0x02,0x01.
6. Empty, push+pop 0x77 -> underflow=1, count=1, next pop 0x77. Assert reset_n low mid-stream asynchronously -> count=0 and flags=0 immediately, without waiting for a clock edge.
